// File: rtl/can_tx_if.sv
// Command/status bundle between the CAN register file, the bit-stream
// processor and the transmit request controller.
interface can_tx_if;
  logic       reset_mode;
  logic       tx_request;
  logic       abort_tx;
  logic       self_rx_request;
  logic       bus_idle;
  logic       tx_ack;
  logic       tx_done_ok;
  logic       arb_lost;
  logic       tx_error;
  logic       transmit_buffer_status;
  logic       transmission_complete;
  logic       transmit_status;
  logic       tx_start;
  logic       self_rx;
  logic       single_shot;
  logic       tx_irq;
  logic [3:0] retry_cnt;

  modport master (
    output reset_mode, tx_request, abort_tx, self_rx_request,
           bus_idle, tx_ack, tx_done_ok, arb_lost, tx_error,
    input  transmit_buffer_status, transmission_complete, transmit_status,
           tx_start, self_rx, single_shot, tx_irq, retry_cnt
  );

  modport slave (
    input  reset_mode, tx_request, abort_tx, self_rx_request,
           bus_idle, tx_ack, tx_done_ok, arb_lost, tx_error,
    output transmit_buffer_status, transmission_complete, transmit_status,
           tx_start, self_rx, single_shot, tx_irq, retry_cnt
  );
endinterface

// File: rtl/can_tx_ctrl.sv
// CAN transmit request controller: tracks a pending/active TX request,
// handles retransmission, abort, single-shot and self-reception modes.
module can_tx_ctrl (
  input  logic     clk,
  input  logic     rst,
  can_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_tbs, w_tbs_nxt;
  logic       r_tcs, w_tcs_nxt;
  logic       r_ts, w_ts_nxt;
  logic       r_self_rx, w_self_rx_nxt;
  logic       r_single_shot, w_single_shot_nxt;
  logic       r_irq, w_irq_nxt;
  logic       r_abort_pending, w_abort_pending_nxt;
  logic [3:0] r_retry_cnt, w_retry_cnt_nxt;

  logic w_in_idle, w_in_pend, w_in_active;
  logic w_start, w_pend_abort, w_pend_ack, w_done, w_loss, w_give_up, w_retry;
  logic w_finish, w_set_abort;

  assign w_in_idle   = (r_state == IDLE);
  assign w_in_pend   = (r_state == PEND);
  assign w_in_active = (r_state == ACTIVE);

  // Event decode; everything below is already masked by reset_mode.
  assign w_start      = !bus.reset_mode && w_in_idle && (bus.tx_request || bus.self_rx_request);
  assign w_pend_ack   = !bus.reset_mode && w_in_pend && bus.tx_ack;
  assign w_pend_abort = !bus.reset_mode && w_in_pend && bus.abort_tx && !bus.tx_ack;
  assign w_done       = !bus.reset_mode && w_in_active && bus.tx_done_ok;
  assign w_loss       = !bus.reset_mode && w_in_active && !bus.tx_done_ok &&
                        (bus.arb_lost || bus.tx_error);
  // An abort arriving together with the loss counts as already pending.
  assign w_give_up    = w_loss && (r_single_shot || r_abort_pending || bus.abort_tx);
  assign w_retry      = w_loss && !w_give_up;
  assign w_finish     = w_pend_abort || w_done || w_give_up;
  assign w_set_abort  = bus.abort_tx && (w_pend_ack ||
                        (!bus.reset_mode && w_in_active && !w_done && !w_loss));

  // State register plus registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_tbs           <= 1'b1;
      r_tcs           <= 1'b1;
      r_ts            <= 1'b0;
      r_self_rx       <= 1'b0;
      r_single_shot   <= 1'b0;
      r_irq           <= 1'b0;
      r_abort_pending <= 1'b0;
      r_retry_cnt     <= 4'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_tbs           <= w_tbs_nxt;
      r_tcs           <= w_tcs_nxt;
      r_ts            <= w_ts_nxt;
      r_self_rx       <= w_self_rx_nxt;
      r_single_shot   <= w_single_shot_nxt;
      r_irq           <= w_irq_nxt;
      r_abort_pending <= w_abort_pending_nxt;
      r_retry_cnt     <= w_retry_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (bus.reset_mode) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start) w_state_nxt = PEND;
        PEND:    if (w_pend_ack) w_state_nxt = ACTIVE;
                 else if (w_pend_abort) w_state_nxt = IDLE;
        ACTIVE:  if (w_done || w_give_up) w_state_nxt = IDLE;
                 else if (w_retry) w_state_nxt = PEND;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output / status next values
  always_comb begin
    w_tbs_nxt           = r_tbs;
    w_tcs_nxt           = r_tcs;
    w_self_rx_nxt       = r_self_rx;
    w_single_shot_nxt   = r_single_shot;
    w_abort_pending_nxt = r_abort_pending;
    w_retry_cnt_nxt     = r_retry_cnt;
    w_irq_nxt           = 1'b0;
    w_ts_nxt            = (w_state_nxt == ACTIVE);
    if (bus.reset_mode) begin
      w_tbs_nxt           = 1'b1;
      w_tcs_nxt           = 1'b1;
      w_self_rx_nxt       = 1'b0;
      w_single_shot_nxt   = 1'b0;
      w_abort_pending_nxt = 1'b0;
      w_retry_cnt_nxt     = 4'd0;
    end else begin
      if (w_start) begin
        w_tbs_nxt         = 1'b0;
        w_tcs_nxt         = 1'b0;
        w_retry_cnt_nxt   = 4'd0;
        w_self_rx_nxt     = bus.self_rx_request;
        // SJA1000 encodes single-shot as TR together with AT.
        w_single_shot_nxt = bus.abort_tx;
      end
      if (w_set_abort) w_abort_pending_nxt = 1'b1;
      if (w_retry && r_retry_cnt != 4'd15) w_retry_cnt_nxt = r_retry_cnt + 4'd1;
      if (w_finish) begin
        w_tbs_nxt           = 1'b1;
        w_tcs_nxt           = w_done;
        w_irq_nxt           = 1'b1;
        w_abort_pending_nxt = 1'b0;
      end
    end
  end

  assign bus.transmit_buffer_status = r_tbs;
  assign bus.transmission_complete  = r_tcs;
  assign bus.transmit_status        = r_ts;
  assign bus.tx_start               = w_in_pend && bus.bus_idle;
  assign bus.self_rx                = r_self_rx;
  assign bus.single_shot            = r_single_shot;
  assign bus.tx_irq                 = r_irq;
  assign bus.retry_cnt              = r_retry_cnt;

endmodule
